// File: rtl/vector_index_sequencer.sv
// vector_index_sequencer
//   Steps a vector index through a runtime-programmable number of vectors,
//   counts completed passes over the vector set and reports done after a
//   programmed number of passes (or runs forever when num_passes is 0).
//   Sits between the layer controller and the weight/input address logic.
//
// Optional feature macro: VECTOR_INDEX_ONEHOT_EN
//   When defined, adds a registered one-hot copy of the index (index_onehot).
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-high reset
//   en            global enable; low holds all state except clear
//   clear         synchronous abort back to IDLE
//   start         begin a run (honoured in IDLE or DONE)
//   vector_count  vectors per pass, latched at start (0 -> NUM_VECTORS)
//   num_passes    passes per run, latched at start (0 -> continuous)
//   new_vector    advance the index by one
//   vector_index  current vector index (registered)
//   first_vector  busy and index == 0
//   last_vector   busy and index == latched limit
//   wrap          one-cycle pulse after the index wraps to 0
//   pass_count    completed passes in the current run
//   busy / done   RUN / DONE state indicators
//   index_onehot  (optional) one-hot index while busy, else zero
module vector_index_sequencer #(
  parameter int INDEX_WIDTH = 4,
  parameter int NUM_VECTORS = 4,
  parameter int PASS_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] vector_count,
  input  logic [PASS_WIDTH-1:0]  num_passes,
  input  logic                   new_vector,
  output logic [INDEX_WIDTH-1:0] vector_index,
  output logic                   first_vector,
  output logic                   last_vector,
  output logic                   wrap,
  output logic [PASS_WIDTH-1:0]  pass_count,
  output logic                   busy,
  output logic                   done
`ifdef VECTOR_INDEX_ONEHOT_EN
  ,
  output logic [2**INDEX_WIDTH-1:0] index_onehot
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // NUM_VECTORS may equal 2**INDEX_WIDTH, so compare one bit wider.
  localparam logic [INDEX_WIDTH:0]   NUM_V     = (INDEX_WIDTH+1)'(NUM_VECTORS);
  localparam logic [INDEX_WIDTH-1:0] DEF_LIMIT = INDEX_WIDTH'(NUM_VECTORS - 1);

  state_t                 state_q, state_n;
  logic [INDEX_WIDTH-1:0] idx_q, idx_n;
  logic [INDEX_WIDTH-1:0] limit_q, limit_n;
  logic [PASS_WIDTH-1:0]  pass_q, pass_n, pass_inc;
  logic [PASS_WIDTH-1:0]  target_q, target_n;
  logic                   wrap_q, wrap_n;

  // Highest index of a pass: zero selects the default count, larger
  // requests are clamped to NUM_VECTORS.
  function automatic logic [INDEX_WIDTH-1:0] calc_limit(input logic [INDEX_WIDTH-1:0] vc);
    logic [INDEX_WIDTH:0] n;
    if (vc == '0)
      n = NUM_V;
    else if ({1'b0, vc} > NUM_V)
      n = NUM_V;
    else
      n = {1'b0, vc};
    n = n - 1'b1;
    return n[INDEX_WIDTH-1:0];
  endfunction

  assign pass_inc = pass_q + 1'b1;

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    limit_n  = limit_q;
    pass_n   = pass_q;
    target_n = target_q;
    wrap_n   = wrap_q;
    if (clear) begin
      state_n = S_IDLE;
      idx_n   = '0;
      pass_n  = '0;
      wrap_n  = 1'b0;
    end else if (en) begin
      wrap_n = 1'b0;
      unique case (state_q)
        S_RUN: begin
          if (new_vector) begin
            if (idx_q == limit_q) begin
              idx_n  = '0;
              wrap_n = 1'b1;
              pass_n = pass_inc;
              // A zero target never matches: continuous mode wraps silently.
              if (target_q != '0 && pass_inc == target_q)
                state_n = S_DONE;
            end else begin
              idx_n = idx_q + 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            limit_n  = calc_limit(vector_count);
            target_n = num_passes;
            idx_n    = '0;
            pass_n   = '0;
            state_n  = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      limit_q  <= DEF_LIMIT;
      pass_q   <= '0;
      target_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      limit_q  <= limit_n;
      pass_q   <= pass_n;
      target_q <= target_n;
      wrap_q   <= wrap_n;
    end
  end

`ifdef VECTOR_INDEX_ONEHOT_EN
  logic [2**INDEX_WIDTH-1:0] onehot_n;

  // Derived from the next state so it moves on the same edge as the index.
  always_comb begin
    onehot_n = '0;
    if (state_n == S_RUN)
      onehot_n[idx_n] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      index_onehot <= '0;
    else
      index_onehot <= onehot_n;
  end
`endif

  assign vector_index = idx_q;
  assign pass_count   = pass_q;
  assign wrap         = wrap_q;
  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign first_vector = busy && (idx_q == '0);
  assign last_vector  = busy && (idx_q == limit_q);

endmodule

// File: tb/tb_vector_index_sequencer.sv
module tb_vector_index_sequencer;

  localparam int IW  = 4;
  localparam int NV  = 4;
  localparam int PW  = 8;
  localparam int OHW = 2**IW;

  logic          clock, reset, en, clear, start, new_vector;
  logic [IW-1:0] vector_count, vector_index;
  logic [PW-1:0] num_passes, pass_count;
  logic          first_vector, last_vector, wrap, busy, done;
  logic [OHW-1:0] oh_act;

`ifdef VECTOR_INDEX_ONEHOT_EN
  logic [OHW-1:0] index_onehot;
  assign oh_act = index_onehot;
`else
  assign oh_act = '0;
`endif

  vector_index_sequencer #(.INDEX_WIDTH(IW), .NUM_VECTORS(NV), .PASS_WIDTH(PW)) dut (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .start(start),
    .vector_count(vector_count), .num_passes(num_passes), .new_vector(new_vector),
    .vector_index(vector_index), .first_vector(first_vector), .last_vector(last_vector),
    .wrap(wrap), .pass_count(pass_count), .busy(busy), .done(done)
`ifdef VECTOR_INDEX_ONEHOT_EN
    , .index_onehot(index_onehot)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [IW-1:0]  idx;
    logic           first;
    logic           last;
    logic           wrp;
    logic [PW-1:0]  pc;
    logic           bsy;
    logic           dn;
    logic [OHW-1:0] oh;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: run/finished flags and integer counters.
  bit m_run, m_fin, m_wrap;
  int m_idx, m_pc, m_lim, m_tgt;

  function automatic int ref_limit(input int vc);
    int n;
    n = (vc == 0) ? NV : ((vc > NV) ? NV : vc);
    return n - 1;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.idx   = IW'(m_idx);
    o.first = m_run && (m_idx == 0);
    o.last  = m_run && (m_idx == m_lim);
    o.wrp   = m_wrap;
    o.pc    = PW'(m_pc);
    o.bsy   = m_run;
    o.dn    = m_fin;
`ifdef VECTOR_INDEX_ONEHOT_EN
    o.oh    = m_run ? (OHW'(1) << m_idx) : '0;
`else
    o.oh    = '0;
`endif
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_wrap = 0;
    m_idx = 0; m_pc = 0; m_lim = NV - 1; m_tgt = 0;
  endtask

  task automatic model_clock(input bit c, e, s, n, input int vc, input int np);
    if (c) begin
      m_run = 0; m_fin = 0; m_idx = 0; m_pc = 0; m_wrap = 0;
    end else if (e) begin
      bit w;
      w = 0;
      if (m_run) begin
        if (n) begin
          if (m_idx == m_lim) begin
            m_idx = 0;
            w = 1;
            m_pc = (m_pc + 1) % (1 << PW);
            if (m_tgt != 0 && m_pc == m_tgt) begin
              m_run = 0;
              m_fin = 1;
            end
          end else begin
            m_idx = m_idx + 1;
          end
        end
      end else if (s) begin
        m_lim = ref_limit(vc);
        m_tgt = np;
        m_idx = 0;
        m_pc  = 0;
        m_run = 1;
        m_fin = 0;
      end
      m_wrap = w;
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input bit r, e, c, s, n, input int vc, input int np);
    @(negedge clock);
    reset = r; en = e; clear = c; start = s; new_vector = n;
    vector_count = IW'(vc); num_passes = PW'(np);
    if (r) model_reset();
    else   model_clock(c, e, s, n, vc, np);
    exp_q.push_back(model_obs());
  endtask

  task automatic pulses(input int k);
    for (int i = 0; i < k; i++) begin
      step(0, 1, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
    end
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  initial begin
    obs_t got, ex;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        got.idx = vector_index; got.first = first_vector; got.last = last_vector;
        got.wrp = wrap; got.pc = pass_count; got.bsy = busy; got.dn = done; got.oh = oh_act;
        checks++;
        if (got !== ex) begin
          errors++;
          $display("FAIL outputs cyc=%0d got idx=%0d first=%b last=%b wrap=%b pc=%0d busy=%b done=%b oh=%h exp idx=%0d first=%b last=%b wrap=%b pc=%0d busy=%b done=%b oh=%h",
                   cyc, got.idx, got.first, got.last, got.wrp, got.pc, got.bsy, got.dn, got.oh,
                   ex.idx, ex.first, ex.last, ex.wrp, ex.pc, ex.bsy, ex.dn, ex.oh);
        end
      end
      cyc++;
    end
  end

  initial begin
    reset = 1; en = 0; clear = 0; start = 0; new_vector = 0;
    vector_count = '0; num_passes = '0;
    model_reset();

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Default count, two passes.
    step(0, 1, 0, 1, 0, 0, 2);
    pulses(8);
    step(0, 1, 0, 0, 1, 0, 0);           // ignored in DONE

    // Restart from DONE: three vectors, one pass.
    step(0, 1, 0, 1, 0, 3, 1);
    pulses(3);

    // Clamp 9 -> 4 vectors.
    step(0, 1, 0, 1, 0, 9, 1);
    pulses(4);

    // Single vector: every pulse wraps.
    step(0, 1, 0, 1, 0, 1, 3);
    pulses(3);

    // Enable hold then clear beats new_vector at index 3.
    step(0, 1, 0, 1, 0, 4, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);

    // Wrap pulse stretched while enable is low.
    step(0, 1, 0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset at index 2 in RUN.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    @(posedge clock);
    #3;
    reset = 1;
    #1;
    checks++;
    if ({vector_index, first_vector, last_vector, wrap, pass_count, busy, done, oh_act} !== '0) begin
      errors++;
      $display("FAIL async_reset idx=%0d first=%b last=%b wrap=%b pc=%0d busy=%b done=%b oh=%h required all zero",
               vector_index, first_vector, last_vector, wrap, pass_count, busy, done, oh_act);
    end
    model_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Continuous mode: 256 passes of 2 vectors, pass_count wraps to 0.
    step(0, 1, 0, 1, 0, 2, 0);
    for (int i = 0; i < 512; i++) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(0, ($urandom % 8) != 0, ($urandom % 50) == 0, ($urandom % 8) == 0,
           $urandom % 2, int'($urandom % 16), int'($urandom % 4));

    @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_index_sequencer.md
Name: vector_index_sequencer

Overview:
Parametrised successor of the fixed 2-bit vector index counter. It steps a vector index through a runtime-programmable number of vectors, counts complete passes over the vector set, and signals done after a programmed pass count. It sits between the layer controller and the weight/input memory address logic of a neural-net layer. It adds a start/busy/done handshake, first/last/wrap flags and a continuous mode.

Parameters:
INDEX_WIDTH, 4, width of vector_index and vector_count; max supported vectors = 2**INDEX_WIDTH
NUM_VECTORS, 4, default vector count used when vector_count==0; must satisfy 1 <= NUM_VECTORS <= 2**INDEX_WIDTH
PASS_WIDTH, 8, width of num_passes and pass_count

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  global enable; when low, all state holds except clear
clear  input  1  synchronous abort; returns to IDLE
start  input  1  begin a run; sampled in IDLE or DONE only
vector_count  input  INDEX_WIDTH  vectors per pass, latched at start; 0 selects NUM_VECTORS
num_passes  input  PASS_WIDTH  passes per run, latched at start; 0 = continuous (never done)
new_vector  input  1  advance the index by one vector
vector_index  output  INDEX_WIDTH  current vector index (registered)
first_vector  output  1  high when busy && vector_index==0
last_vector  output  1  high when busy && vector_index==latched limit
wrap  output  1  one-cycle pulse on the cycle after the index wraps from limit to 0
pass_count  output  PASS_WIDTH  completed passes in the current run
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (async): state=IDLE, vector_index=0, pass_count=0, wrap=0, internal limit=NUM_VECTORS-1, passes target=0. All flags are 0.
- Priority per clock edge: clear > !en (hold) > FSM actions.
- clear: next state=IDLE; vector_index=0; pass_count=0; wrap=0; latched limit and target are retained.
- States:
  - IDLE: on start, latch limit = (vector_count==0 ? NUM_VECTORS-1 : min(vector_count, NUM_VECTORS)-1) and target=num_passes. Clear vector_index and pass_count, then go to RUN. new_vector is ignored.
  - RUN: on new_vector with index != limit, index+1. On new_vector with index == limit, index=0, wrap=1 next cycle, pass_count+1. If target!=0 and pass_count+1==target, go to DONE. start is ignored in RUN.
  - DONE: index holds 0 and pass_count holds the target. On start, behave as in IDLE (relatch, go to RUN). new_vector is ignored.
- limit==0 (one vector): every accepted new_vector wraps. first_vector and last_vector are both high.
- Continuous mode (target=0): pass_count wraps modulo 2**PASS_WIDTH silently. No done.
- Clamp rule: vector_count > NUM_VECTORS is clamped to NUM_VECTORS.
- wrap is registered, deasserts the following cycle, and is forced 0 by clear.
- en low freezes wrap as well; the pulse extends while en stays low.
- first_vector and last_vector are combinational from state, index and limit. Both are 0 outside RUN.
- No arithmetic overflow of vector_index is possible because index <= limit < 2**INDEX_WIDTH.

Optional Feature:
VECTOR_INDEX_ONEHOT_EN
- Defined: adds output index_onehot [2**INDEX_WIDTH-1:0], registered. Bit vector_index is set while busy; the output is all-zero otherwise and at reset. It updates on the same edge as vector_index, with no added latency.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run: assert reset asynchronously at index 2 in RUN. Required: all outputs 0 immediately, before the next clock edge, and state=IDLE.
- Default count: vector_count=0, num_passes=2, start, then 8 new_vector pulses. Required: index sequence 0,1,2,3,0,1,2,3,0; wrap pulses after the 4th and 8th pulses; done after the 8th; pass_count=2.
- Clamp and single vector: vector_count=9 with NUM_VECTORS=4 gives limit=3. vector_count=1 gives index stuck at 0, first_vector=last_vector=1, and a wrap on every new_vector.
- Enable and clear priority: en=0 with new_vector=1 for 3 cycles gives index unchanged. clear and new_vector together at index 3 give index=0, IDLE, wrap=0.
- Continuous mode: num_passes=0, PASS_WIDTH=8, vector_count=2, 512 new_vector pulses. Required: pass_count wraps 255→0, done is never asserted, busy stays 1.
- Restart from DONE: in DONE, start with vector_count=3, num_passes=1. Required: RUN; after 3 pulses, done=1 and pass_count=1; index_onehot follows 001,010,100 when VECTOR_INDEX_ONEHOT_EN is defined.
